// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - iterative signed 32-bit multiply/divide unit with fixed 33-cycle latency
//
// One shared 65-bit {hi_q, lo_q} register pair does both jobs. Multiply runs a
// right-shifting shift-add with the multiplier in lo_q. Divide runs a left-shifting
// restoring divide: the dividend starts in lo_q and the quotient bits replace it.
// Both operate on magnitudes; the sign is fixed up on the edge that enters DONE.

module multdiv_ctrl (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        sign_a_q;
    logic        sign_b_q;
    logic [32:0] mag_q;      // multiplicand (MUL) or divisor (DIV) magnitude
    logic [32:0] hi_q;       // product high part (MUL) or partial remainder (DIV)
    logic [31:0] lo_q;       // multiplier / dividend, shifted out as quotient/product bits arrive
    logic [31:0] result_q;
    logic        exc_q;
    logic        rdy_q;

    logic        start;
    logic [32:0] mag_a;
    logic [32:0] mag_b;
    logic [33:0] mul_sum;
    logic [32:0] mul_hi_d;
    logic [31:0] mul_lo_d;
    logic [32:0] rem_sh;
    logic [33:0] trial;
    logic [32:0] div_hi_d;
    logic [31:0] div_lo_d;
    logic        neg;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic        mul_exc;
    logic        div_zero;
    logic [31:0] quot;
    logic [31:0] div_res;
    logic        div_exc;

    assign start = ctrl_MULT | ctrl_DIV;

    // Operand magnitudes, 33 bits so that |0x80000000| = 2^31 is representable
    always_comb begin
        mag_a = data_operandA[31] ? (33'd0 - {1'b1, data_operandA}) : {1'b0, data_operandA};
        mag_b = data_operandB[31] ? (33'd0 - {1'b1, data_operandB}) : {1'b0, data_operandB};
    end

    // One shift-add step: add multiplicand when the current multiplier bit is set, shift right
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : 34'd0);
        mul_hi_d = mul_sum[33:1];
        mul_lo_d = {mul_sum[0], lo_q[31:1]};
    end

    // One restoring-divide step: shift next dividend bit into the remainder, keep the subtraction if it fits
    always_comb begin
        rem_sh = {hi_q[31:0], lo_q[31]};
        trial  = {1'b0, rem_sh} - {1'b0, mag_q};
        if (!trial[33]) begin
            div_hi_d = trial[32:0];
            div_lo_d = {lo_q[30:0], 1'b1};
        end else begin
            div_hi_d = rem_sh;
            div_lo_d = {lo_q[30:0], 1'b0};
        end
    end

    // Sign correction and exception detection for the finished magnitude result
    always_comb begin
        neg      = sign_a_q ^ sign_b_q;
        prod_mag = {hi_q[31:0], lo_q};
        prod     = neg ? (64'd0 - prod_mag) : prod_mag;
        mul_exc  = (prod[63:32] != {32{prod[31]}});
        div_zero = (mag_q == 33'd0);
        quot     = neg ? (32'd0 - lo_q) : lo_q;
        // A positive quotient of magnitude 2^31 only arises from 0x80000000 / -1
        div_exc  = div_zero | (~neg & lo_q[31]);
        div_res  = div_zero ? 32'd0 : quot;
    end

    // Control FSM and datapath: a start pulse in any state reloads and restarts
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_q    <= 33'd0;
            hi_q     <= 33'd0;
            lo_q     <= 32'd0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else if (start) begin
            cnt_q    <= 6'd0;
            sign_a_q <= data_operandA[31];
            sign_b_q <= data_operandB[31];
            hi_q     <= 33'd0;
            rdy_q    <= 1'b0;
            if (ctrl_MULT) begin
                state_q <= S_MUL;
                mag_q   <= mag_a;
                lo_q    <= mag_b[31:0];
            end else begin
                state_q <= S_DIV;
                mag_q   <= mag_b;
                lo_q    <= mag_a[31:0];
            end
        end else begin
            case (state_q)
                S_MUL, S_DIV: begin
                    // cnt_q reaches 32 only after the 32nd iteration, so bit 5 ends the loop
                    if (cnt_q[5]) begin
                        state_q  <= S_DONE;
                        rdy_q    <= 1'b1;
                        result_q <= (state_q == S_MUL) ? prod[31:0] : div_res;
                        exc_q    <= (state_q == S_MUL) ? mul_exc : div_exc;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                        hi_q  <= (state_q == S_MUL) ? mul_hi_d : div_hi_d;
                        lo_q  <= (state_q == S_MUL) ? mul_lo_d : div_lo_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb/tb_multdiv_ctrl.sv - scoreboard bench for multdiv_ctrl

module tb_multdiv_ctrl;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent reference: 64-bit signed arithmetic
    function automatic exp_t model(input logic is_mul, input logic [31:0] a, input logic [31:0] b);
        exp_t                e;
        logic signed [63:0]  sa;
        logic signed [63:0]  sb;
        logic signed [63:0]  p;
        logic signed [31:0]  q;
        logic signed [63:0]  lo_ext;
        sa = $signed(a);
        sb = $signed(b);
        if (is_mul) begin
            p      = sa * sb;
            lo_ext = $signed(p[31:0]);
            e.res  = p[31:0];
            e.exc  = (p != lo_ext);
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge that sampled the pulse
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Observes up to max_cycles edges; index k means "sampled after the k-th edge since start"
    task automatic watch(input int max_cycles, input bit stop_on_rdy, output int n_rdy,
                         output int first_at, output logic [31:0] res, output logic exc);
        n_rdy    = 0;
        first_at = -1;
        res      = 'x;
        exc      = 1'bx;
        for (int k = 1; k <= max_cycles; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                n_rdy++;
                if (first_at < 0) begin
                    first_at = k;
                    res      = data_result;
                    exc      = data_exception;
                end
                if (stop_on_rdy) break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (data_result !== 32'd0) $display("FAIL reset_result: got %h, required 00000000", data_result);
        else passed++;
        checks++;
        if (data_exception !== 1'b0) $display("FAIL reset_exc: got %b, required 0", data_exception);
        else passed++;
        checks++;
        if (data_resultRDY !== 1'b0) $display("FAIL reset_rdy: got %b, required 0", data_resultRDY);
        else passed++;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_mul();
        logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] tb [4] = '{32'd6,         32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tr [4] = '{32'hFFFF_FFD6, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000};
        logic        te [4] = '{1'b0,          1'b1,          1'b0,          1'b1};
        exp_t e;
        int n, at;
        logic [31:0] r;
        logic x;
        for (int i = 0; i < 4; i++) begin
            start_op(1'b1, 1'b0, ta[i], tb[i]);
            sb_q.push_back('{res: tr[i], exc: te[i]});
            watch(40, 1'b0, n, at, r, x);
            e = sb_q.pop_front();
            checks++;
            if (n !== 1 || at !== 33) $display("FAIL mul_latency[%0d]: rdy_count=%0d first_at=%0d, required 1 at 33", i, n, at);
            else passed++;
            checks++;
            if (r !== e.res) $display("FAIL mul_result[%0d]: got %h, required %h", i, r, e.res);
            else passed++;
            checks++;
            if (x !== e.exc) $display("FAIL mul_exc[%0d]: got %b, required %b", i, x, e.exc);
            else passed++;
        end
    endtask

    task automatic test_div();
        logic [31:0] ta [4] = '{32'd100, 32'd7,         32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb [4] = '{32'd0,   32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFF};
        logic [31:0] tr [4] = '{32'd0,   32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
        logic        te [4] = '{1'b1,    1'b0,          1'b0,          1'b1};
        exp_t e;
        int n, at;
        logic [31:0] r;
        logic x;
        for (int i = 0; i < 4; i++) begin
            start_op(1'b0, 1'b1, ta[i], tb[i]);
            sb_q.push_back('{res: tr[i], exc: te[i]});
            watch(40, 1'b0, n, at, r, x);
            e = sb_q.pop_front();
            checks++;
            if (n !== 1 || at !== 33) $display("FAIL div_latency[%0d]: rdy_count=%0d first_at=%0d, required 1 at 33", i, n, at);
            else passed++;
            checks++;
            if (r !== e.res) $display("FAIL div_result[%0d]: got %h, required %h", i, r, e.res);
            else passed++;
            checks++;
            if (x !== e.exc) $display("FAIL div_exc[%0d]: got %b, required %b", i, x, e.exc);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int n, at;
        logic [31:0] r;
        logic x;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0)
            $display("FAIL reset_mid_outputs: got result=%h exc=%b rdy=%b, required 0/0/0",
                     data_result, data_exception, data_resultRDY);
        else passed++;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        watch(40, 1'b0, n, at, r, x);
        checks++;
        if (n !== 0) $display("FAIL reset_mid_no_rdy: got %0d RDY pulses, required 0", n);
        else passed++;
    endtask

    task automatic test_restart();
        exp_t e;
        int n, at;
        logic [31:0] r;
        logic x;
        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        watch(19, 1'b0, n, at, r, x);
        checks++;
        if (n !== 0) $display("FAIL restart_early_rdy: got %0d RDY pulses, required 0", n);
        else passed++;
        start_op(1'b0, 1'b1, 32'd20, 32'd4);
        sb_q.push_back('{res: 32'd5, exc: 1'b0});
        watch(45, 1'b0, n, at, r, x);
        e = sb_q.pop_front();
        checks++;
        if (n !== 1 || at !== 33) $display("FAIL restart_latency: rdy_count=%0d first_at=%0d, required 1 at 33", n, at);
        else passed++;
        checks++;
        if (r !== e.res || x !== e.exc) $display("FAIL restart_result: got %h/%b, required %h/%b", r, x, e.res, e.exc);
        else passed++;
    endtask

    task automatic test_priority();
        exp_t e;
        int n, at;
        logic [31:0] r;
        logic x;
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        sb_q.push_back('{res: 32'd18, exc: 1'b0});
        watch(40, 1'b0, n, at, r, x);
        e = sb_q.pop_front();
        checks++;
        if (n !== 1 || at !== 33) $display("FAIL priority_latency: rdy_count=%0d first_at=%0d, required 1 at 33", n, at);
        else passed++;
        checks++;
        if (r !== e.res || x !== e.exc) $display("FAIL priority_result: got %h/%b, required %h/%b", r, x, e.res, e.exc);
        else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int n, at;
        logic [31:0] r;
        logic x;
        start_op(1'b1, 1'b0, 32'd7, 32'd9);
        sb_q.push_back('{res: 32'd63, exc: 1'b0});
        watch(40, 1'b1, n, at, r, x);
        e = sb_q.pop_front();
        checks++;
        if (n !== 1 || at !== 33) $display("FAIL b2b_first_latency: rdy_count=%0d first_at=%0d, required 1 at 33", n, at);
        else passed++;
        checks++;
        if (r !== e.res || x !== e.exc) $display("FAIL b2b_first_result: got %h/%b, required %h/%b", r, x, e.res, e.exc);
        else passed++;
        // Now inside the DONE cycle: this pulse is sampled on the edge that leaves DONE
        start_op(1'b1, 1'b0, 32'd2, 32'd3);
        sb_q.push_back('{res: 32'd6, exc: 1'b0});
        watch(40, 1'b0, n, at, r, x);
        e = sb_q.pop_front();
        checks++;
        if (n !== 1 || at !== 33) $display("FAIL b2b_second_latency: rdy_count=%0d first_at=%0d, required 1 at 33", n, at);
        else passed++;
        checks++;
        if (r !== e.res || x !== e.exc) $display("FAIL b2b_second_result: got %h/%b, required %h/%b", r, x, e.res, e.exc);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] pool [5] = '{32'h8000_0000, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        exp_t e;
        int n, at;
        logic [31:0] r;
        logic x;
        logic [31:0] a, b;
        logic m;
        for (int i = 0; i < 10; i++) begin
            a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 4)] : ($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            m = 1'($urandom_range(0, 1));
            start_op(m, ~m, a, b);
            sb_q.push_back(model(m, a, b));
            watch(40, 1'b0, n, at, r, x);
            e = sb_q.pop_front();
            checks++;
            if (n !== 1 || at !== 33 || r !== e.res || x !== e.exc)
                $display("FAIL random[%0d] %s %h,%h: got rdy=%0d@%0d %h/%b, required 1@33 %h/%b",
                         i, m ? "mul" : "div", a, b, n, at, r, x, e.res, e.exc);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_reset_mid();
        test_restart();
        test_priority();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
